// File: rtl/ste_bus_pkg.sv
// ste_bus_pkg: shared types and the wrap-around first-set search for the bus arbiter
package ste_bus_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_GRANT, ARB_RELEASE} arb_state_t;
    localparam int ARB_MAXREQ = 8;
    function automatic logic [ARB_MAXREQ-1:0] onehot_first(input logic [ARB_MAXREQ-1:0] vec, input int start, input int n);
        logic [ARB_MAXREQ-1:0] r;
        int j;
        r = '0;
        for (int k = ARB_MAXREQ - 1; k >= 0; k--) begin
            j = (start + k) % n;
            if (k < n && vec[j]) begin
                r = '0;
                r[j] = 1'b1;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/ste_arb_pick.sv
// ste_arb_pick: combinational winner selector, fixed priority or round robin from ptr
module ste_arb_pick
    import ste_bus_pkg::*;
#(
    parameter int NREQ = 4,
    parameter bit RR = 1'b0,
    parameter int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   idx,
    output logic            valid
);
    logic [ARB_MAXREQ-1:0] vec, oh;
    always_comb begin
        vec = '0;
        vec[NREQ-1:0] = req;
        oh = onehot_first(vec, RR ? int'(ptr) : 0, NREQ);
        idx = '0;
        for (int i = 0; i < ARB_MAXREQ; i++)
            if (oh[i]) idx = PW'(i);
    end
    assign valid = |req;
endmodule

// File: rtl/ste_bus_arbiter.sv
// ste_bus_arbiter: 68000 BR/BG/BGACK arbiter for NREQ masters; ARB_ROUND_ROBIN_EN selects round robin over fixed priority
module ste_bus_arbiter
    import ste_bus_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int MAXHOLD = 0
) (
    input  logic            clk32,
    input  logic            res,
    input  logic            clk_en,
    input  logic            as_n,
    input  logic            bg_n,
    input  logic [NREQ-1:0] req,
    output logic            br_n,
    output logic            bgack_n,
    output logic [NREQ-1:0] gnt,
    output logic            preempt,
    output logic            bus_free
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;
    arb_state_t state, state_n;
    logic [PW-1:0] widx, widx_n, ptr, pick_idx;
    logic [HW-1:0] hold, hold_n, hold_inc;
    logic [NREQ-1:0] gnt_n, pick_oh;
    logic pick_valid, br_n_n, bgack_n_n, preempt_n;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
    always_ff @(posedge clk32)
        if (res) ptr <= '0;
        else if (clk_en && state == ARB_GRANT && !req[widx]) ptr <= (widx == PW'(NREQ - 1)) ? '0 : widx + 1'b1;
`else
    localparam bit RR = 1'b0;
    assign ptr = '0;
`endif
    ste_arb_pick #(.NREQ(NREQ), .RR(RR), .PW(PW)) u_pick (
        .req(req), .ptr(ptr), .idx(pick_idx), .valid(pick_valid)
    );
    assign pick_oh = NREQ'(1) << pick_idx;
    assign hold_inc = (hold == HW'(MAXHOLD)) ? hold : hold + 1'b1;
    assign bus_free = (state == ARB_IDLE) && ~|req;
    always_comb begin
        state_n = state;
        widx_n = widx;
        gnt_n = gnt;
        br_n_n = br_n;
        bgack_n_n = bgack_n;
        preempt_n = preempt;
        hold_n = hold;
        case (state)
            ARB_IDLE: begin
                state_n = pick_valid ? ARB_REQ : ARB_IDLE;
                br_n_n = !pick_valid;
            end
            ARB_REQ:
                if (!pick_valid) begin
                    state_n = ARB_IDLE;
                    br_n_n = 1'b1;
                end else if (!bg_n && as_n) begin
                    state_n = ARB_GRANT;
                    widx_n = pick_idx;
                    gnt_n = pick_oh;
                    bgack_n_n = 1'b0;
                    br_n_n = 1'b1;
                    hold_n = HW'(MAXHOLD > 0);
                    preempt_n = MAXHOLD > 0 && hold_n == HW'(MAXHOLD) && |(req & ~pick_oh);
                end
            ARB_GRANT:
                if (!req[widx]) begin
                    state_n = ARB_RELEASE;
                    gnt_n = '0;
                    bgack_n_n = 1'b1;
                    preempt_n = 1'b0;
                    hold_n = '0;
                end else begin
                    hold_n = hold_inc;
                    preempt_n = preempt || (MAXHOLD > 0 && hold_n == HW'(MAXHOLD) && |(req & ~gnt));
                end
            default: begin
                state_n = pick_valid ? ARB_REQ : ARB_IDLE;
                br_n_n = !pick_valid;
            end
        endcase
    end
    always_ff @(posedge clk32)
        if (res) begin
            state <= ARB_IDLE;
            widx <= '0;
            gnt <= '0;
            br_n <= 1'b1;
            bgack_n <= 1'b1;
            preempt <= 1'b0;
            hold <= '0;
        end else if (clk_en) begin
            state <= state_n;
            widx <= widx_n;
            gnt <= gnt_n;
            br_n <= br_n_n;
            bgack_n <= bgack_n_n;
            preempt <= preempt_n;
            hold <= hold_n;
        end
    assert property (@(posedge clk32) $onehot0(gnt));
endmodule

// File: tb/tb_ste_bus_arbiter.sv
// tb_ste_bus_arbiter: vector table, handshake corner sequences and randomized run against a behavioural model
module tb_ste_bus_arbiter;
    localparam int NREQ = 4;
    localparam int MAXHOLD = 3;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk32 = 1'b0, res = 1'b1, clk_en = 1'b1, as_n = 1'b1, bg_n = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic br_n, bgack_n, preempt, bus_free;
    logic [NREQ-1:0] gnt;
    int checks = 0, failures = 0;
    int m_ph = 0, m_w = 0, m_ticks = 0, m_ptr = 0;
    bit m_pre = 1'b0;

    typedef struct {
        string name;
        logic r, ce, as, bg;
        logic [3:0] rq;
        logic [7:0] exp;
    } vec_t;
    vec_t vt[$];

    always #5 clk32 = ~clk32;

    ste_bus_arbiter #(.NREQ(NREQ), .MAXHOLD(MAXHOLD)) dut (
        .clk32(clk32), .res(res), .clk_en(clk_en), .as_n(as_n), .bg_n(bg_n), .req(req),
        .br_n(br_n), .bgack_n(bgack_n), .gnt(gnt), .preempt(preempt), .bus_free(bus_free)
    );

    function automatic int winner(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++)
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        return 0;
    endfunction

    function automatic logic [NREQ-1:0] bit_of(input int i);
        return NREQ'(1) << i;
    endfunction

    task automatic model_step();
        if (res) begin
            m_ph = 0; m_w = 0; m_ticks = 0; m_ptr = 0; m_pre = 1'b0;
        end else if (clk_en) begin
            case (m_ph)
                0: if (req != 0) m_ph = 1;
                1: if (req == 0) m_ph = 0;
                   else if (!bg_n && as_n) begin
                       m_w = winner(req, RR ? m_ptr : 0);
                       m_ph = 2;
                       m_ticks = 1;
                       m_pre = MAXHOLD > 0 && m_ticks >= MAXHOLD && (req & ~bit_of(m_w)) != 0;
                   end
                2: if (!req[m_w]) begin
                       m_ph = 3;
                       m_pre = 1'b0;
                       m_ptr = (m_w + 1) % NREQ;
                   end else begin
                       m_ticks++;
                       if (MAXHOLD > 0 && m_ticks >= MAXHOLD && (req & ~bit_of(m_w)) != 0) m_pre = 1'b1;
                   end
                default: m_ph = (req != 0) ? 1 : 0;
            endcase
        end
    endtask

    function automatic logic [7:0] model_exp();
        logic [NREQ-1:0] g;
        g = (m_ph == 2) ? bit_of(m_w) : '0;
        return {m_ph != 1, m_ph != 2, g, m_pre, m_ph == 0 && req == 0};
    endfunction

    function automatic logic [7:0] outs();
        return {br_n, bgack_n, gnt, preempt, bus_free};
    endfunction

    task automatic tick();
        @(posedge clk32);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: {br_n,bgack_n,gnt,preempt,bus_free} got %b want %b", name, act, exp);
        end
    endtask

    task automatic step(input string name, input logic [3:0] rq, input logic [7:0] exp);
        req = rq;
        tick();
        check(name, outs(), exp);
    endtask

    initial begin
        vt.push_back('{"rst_a",       1, 1, 1, 1, 4'b0000, 8'b11000001});
        vt.push_back('{"rst_b",       1, 1, 1, 1, 4'b0000, 8'b11000001});
        vt.push_back('{"idle",        0, 1, 1, 1, 4'b0000, 8'b11000001});
        vt.push_back('{"single_br",   0, 1, 1, 0, 4'b0001, 8'b01000000});
        vt.push_back('{"single_gnt",  0, 1, 1, 0, 4'b0001, 8'b10000100});
        vt.push_back('{"single_hold", 0, 1, 1, 0, 4'b0001, 8'b10000100});
        vt.push_back('{"single_rel",  0, 1, 1, 0, 4'b0000, 8'b11000000});
        vt.push_back('{"single_idle", 0, 1, 1, 0, 4'b0000, 8'b11000001});
        vt.push_back('{"en_low_a",    0, 0, 1, 0, 4'b0001, 8'b11000000});
        vt.push_back('{"en_low_b",    0, 0, 1, 0, 4'b0001, 8'b11000000});
        vt.push_back('{"as_req",      0, 1, 0, 0, 4'b0001, 8'b01000000});
        vt.push_back('{"as_wait1",    0, 1, 0, 0, 4'b0001, 8'b01000000});
        vt.push_back('{"as_wait2",    0, 1, 0, 0, 4'b0001, 8'b01000000});
        vt.push_back('{"as_wait3",    0, 1, 0, 0, 4'b0001, 8'b01000000});
        vt.push_back('{"as_gnt",      0, 1, 1, 0, 4'b0001, 8'b10000100});
        vt.push_back('{"as_rel",      0, 1, 1, 0, 4'b0000, 8'b11000000});
        vt.push_back('{"as_idle",     0, 1, 1, 0, 4'b0000, 8'b11000001});
        vt.push_back('{"pri_req",     0, 1, 1, 0, 4'b1010, 8'b01000000});
        vt.push_back('{"pri_gnt",     0, 1, 1, 0, 4'b1010, 8'b10001000});
        vt.push_back('{"pri_rel",     0, 1, 1, 0, 4'b1000, 8'b11000000});
        vt.push_back('{"pri_req2",    0, 1, 1, 0, 4'b1000, 8'b01000000});
        vt.push_back('{"pri_gnt2",    0, 1, 1, 0, 4'b1000, 8'b10100000});
        vt.push_back('{"pri_rel2",    0, 1, 1, 0, 4'b0000, 8'b11000000});
        vt.push_back('{"pri_idle",    0, 1, 1, 0, 4'b0000, 8'b11000001});
        vt.push_back('{"drop_req",    0, 1, 1, 1, 4'b0100, 8'b01000000});
        vt.push_back('{"drop_idle",   0, 1, 1, 1, 4'b0000, 8'b11000001});
        foreach (vt[i]) begin
            res = vt[i].r;
            clk_en = vt[i].ce;
            as_n = vt[i].as;
            bg_n = vt[i].bg;
            step(vt[i].name, vt[i].rq, vt[i].exp);
        end

        bg_n = 1'b0;
        as_n = 1'b1;
        step("ph_req",   4'b0001, 8'b01000000);
        step("ph_gnt",   4'b0101, 8'b10000100);
        step("ph_hold2", 4'b0101, 8'b10000100);
        step("ph_pre",   4'b0101, 8'b10000110);
        step("ph_keep",  4'b0101, 8'b10000110);
        step("ph_rel",   4'b0100, 8'b11000000);
        step("ph_req2",  4'b0100, 8'b01000000);
        step("ph_gnt2",  4'b0100, 8'b10010000);
        clk_en = 1'b0;
        res = 1'b1;
        step("rst_mid",  4'b0100, 8'b11000000);
        res = 1'b0;
        clk_en = 1'b1;
        step("post_rst", 4'b0000, 8'b11000001);

        step("alt_req",  4'b0011, 8'b01000000);
        step("alt_g0",   4'b0011, 8'b10000100);
        step("alt_rel0", 4'b0010, 8'b11000000);
        step("alt_req1", 4'b0011, 8'b01000000);
        step("alt_g1",   4'b0011, RR ? 8'b10001000 : 8'b10000100);
        step("alt_rel1", RR ? 4'b0001 : 4'b0010, 8'b11000000);
        step("alt_req2", 4'b0011, 8'b01000000);
        step("alt_g2",   4'b0011, 8'b10000100);

        for (int n = 0; n < 3000; n++) begin
            res = ($urandom_range(0, 199) == 0);
            clk_en = ($urandom_range(0, 3) != 0);
            as_n = ($urandom_range(0, 3) != 0);
            bg_n = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
            tick();
            check("rand", outs(), model_exp());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
